uart_frame_capture: RTL and testbench

//   Parametrised serial-line capture unit: deframes an asynchronous UART stream (start, data LSB-first,

---
 rtl/uart_pkg.sv | 21 ++
 rtl/capture_fifo.sv | 65 ++++++
 rtl/uart_frame_capture.sv | 176 +++++++++++++++++
 tb/tb_uart_frame_capture.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame capture unit: parity modes, FSM
// state encoding and parameter legality helpers.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    function automatic bit stop_bits_legal(input int n);
        return (n == 1) || (n == 2);
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Synchronous first-word-fall-through FIFO: the head word is always on rd_data
// while !empty, and rd_data reads 0 whenever the FIFO is empty.
module capture_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       drop
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             pop_ok;
    logic             push_ok;

    // Handshake: pop is honoured only while !empty; push is honoured unless the
    // FIFO is full with no simultaneous pop, in which case the word is dropped.
    assign empty   = (cnt == '0);
    assign full    = (cnt == FULL_CNT);
    assign level   = cnt;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && !push_ok;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_capture.sv
// UART deframer: synchronises rxd, samples each bit mid-cell and pushes
// {parity_err, frame_err, data} words into a FWFT FIFO.
module uart_frame_capture
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          en,
    input  logic                          rd_en,
    output logic [DATA_BITS+1:0]          rd_data,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overrun,
    input  logic                          clr_err,
    output logic [15:0]                   frame_cnt
);

    localparam int BCW = $clog2(CLKS_PER_BIT);
    localparam logic [BCW-1:0] HALF_LAST = BCW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]     DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]     STOP_LAST = 4'(STOP_BITS - 1);

    if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
        $error("uart_frame_capture: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE > PARITY_ODD) begin : g_bad_params
        $error("uart_frame_capture: illegal CLKS_PER_BIT, DATA_BITS or PARITY_MODE");
    end

    uart_state_t          state;
    logic                 rx_meta;
    logic                 rxs;
    logic                 rxs_q;
    logic                 fall;
    logic [BCW-1:0]       baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic                 frm_err;
    logic                 push;
    logic                 drop;
    logic                 bit_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            rx_meta <= rxd;
            rxs     <= rx_meta;
            rxs_q   <= rxs;
        end
    end

    assign fall     = rxs_q && !rxs;
    assign bit_tick = (baud_cnt == BIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            push     <= 1'b0;
        end else begin
            push <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (en && fall) begin
                        state    <= ST_START;
                        baud_cnt <= '0;
                    end
                end
                // Half-bit wait lands every later sample in the middle of its cell.
                ST_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        par_err  <= 1'b0;
                        frm_err  <= 1'b0;
                        state    <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        shreg    <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        par_err  <= (((^shreg) ^ rxs) != (PARITY_MODE == PARITY_ODD));
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (bit_tick) begin
                        baud_cnt <= '0;
                        if (!rxs) begin
                            frm_err <= 1'b1;
                        end
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= ST_IDLE;
                            push    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Drop sets overrun even when clr_err is asserted in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
            if (push) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    capture_fifo #(
        .WIDTH (DATA_BITS + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({par_err, frm_err, shreg}),
        .pop     (rd_en),
        .rd_data (rd_data),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .drop    (drop)
    );

endmodule

// File: tb/tb_uart_frame_capture.sv
// Bench for uart_frame_capture: three configurations share one serial line and
// are checked against a frame-level reference model.
module tb_uart_frame_capture;

    localparam int CPB    = 4;
    localparam int DB[3]  = '{8, 8, 7};
    localparam int PM[3]  = '{0, 1, 2};
    localparam int SB[3]  = '{1, 2, 1};
    localparam int DEP[3] = '{4, 8, 4};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [2:0]  en = '0;
    logic [2:0]  rd_en = '0;
    logic [2:0]  clr_err = '0;
    logic [9:0]  rd_a, rd_b;
    logic [8:0]  rd_c;
    logic [2:0]  empty_v, full_v, ovr_v;
    logic [2:0]  lvl_a, lvl_c;
    logic [3:0]  lvl_b;
    logic [15:0] fc_a, fc_b, fc_c;

    int          n_vec = 0;
    int          n_err = 0;
    int          push_lat = 0;
    logic [10:0] exp_q0[$];
    logic [10:0] exp_q1[$];
    logic [10:0] exp_q2[$];
    logic [2:0]  ovr_exp = '0;
    int          fc_exp[3] = '{0, 0, 0};

    always #5 clk = ~clk;

    uart_frame_capture #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .rxd(rxd), .en(en[0]), .rd_en(rd_en[0]), .rd_data(rd_a),
        .empty(empty_v[0]), .full(full_v[0]), .level(lvl_a), .overrun(ovr_v[0]),
        .clr_err(clr_err[0]), .frame_cnt(fc_a));

    uart_frame_capture #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(2), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .rxd(rxd), .en(en[1]), .rd_en(rd_en[1]), .rd_data(rd_b),
        .empty(empty_v[1]), .full(full_v[1]), .level(lvl_b), .overrun(ovr_v[1]),
        .clr_err(clr_err[1]), .frame_cnt(fc_b));

    uart_frame_capture #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_c (
        .clk(clk), .rst(rst), .rxd(rxd), .en(en[2]), .rd_en(rd_en[2]), .rd_data(rd_c),
        .empty(empty_v[2]), .full(full_v[2]), .level(lvl_c), .overrun(ovr_v[2]),
        .clr_err(clr_err[2]), .frame_cnt(fc_c));

    function automatic logic [10:0] rd_of(input int w);
        case (w)
            0:       return {1'b0, rd_a};
            1:       return {1'b0, rd_b};
            default: return {2'b0, rd_c};
        endcase
    endfunction

    function automatic int lvl_of(input int w);
        case (w)
            0:       return int'(lvl_a);
            1:       return int'(lvl_b);
            default: return int'(lvl_c);
        endcase
    endfunction

    function automatic logic [15:0] fc_of(input int w);
        case (w)
            0:       return fc_a;
            1:       return fc_b;
            default: return fc_c;
        endcase
    endfunction

    // Reference word from the frame as sent on the line.
    function automatic logic [10:0] exp_word(input int w, input logic [8:0] d, input logic pbit,
                                             input logic [1:0] stops);
        int          ones = 0;
        logic        perr;
        logic        ferr;
        logic [10:0] word;
        for (int i = 0; i < DB[w]; i++) begin
            if (d[i]) ones++;
        end
        if (pbit) ones++;
        perr = (PM[w] == 1) ? (ones % 2 == 1) : (PM[w] == 2) ? (ones % 2 == 0) : 1'b0;
        ferr = !stops[0] || (SB[w] == 2 && !stops[1]);
        word = 11'(d) & ((11'd1 << DB[w]) - 11'd1);
        word = word | (11'(ferr) << DB[w]) | (11'(perr) << (DB[w] + 1));
        return word;
    endfunction

    function automatic int q_size(input int w);
        case (w)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic q_push(input int w, input logic [10:0] v);
        if (q_size(w) >= DEP[w]) begin
            ovr_exp[w] = 1'b1;
        end else begin
            case (w)
                0:       exp_q0.push_back(v);
                1:       exp_q1.push_back(v);
                default: exp_q2.push_back(v);
            endcase
        end
    endtask

    task automatic q_pop(input int w, output logic [10:0] v);
        case (w)
            0:       v = exp_q0.pop_front();
            1:       v = exp_q1.pop_front();
            default: v = exp_q2.pop_front();
        endcase
    endtask

    function automatic logic [10:0] q_head(input int w);
        case (w)
            0:       return exp_q0[0];
            1:       return exp_q1[0];
            default: return exp_q2[0];
        endcase
    endfunction

    task automatic model_frame(input int w, input logic [8:0] d, input logic pbit, input logic [1:0] stops);
        q_push(w, exp_word(w, d, pbit, stops));
        fc_exp[w]++;
    endtask

    // Drives one frame starting at a negedge; the line is left idle high.
    task automatic send_frame(input int w, input logic [8:0] d, input logic pbit, input logic [1:0] stops);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB[w]; i++) begin
            rxd = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (PM[w] != 0) begin
            rxd = pbit;
            repeat (CPB) @(negedge clk);
        end
        for (int i = 0; i < SB[w]; i++) begin
            rxd = stops[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        for (int w = 0; w < 3; w++) begin
            n_vec++; if (empty_v[w] !== 1'b1) begin n_err++; $display("FAIL reset_empty dut%0d got %b want 1", w, empty_v[w]); end
            n_vec++; if (full_v[w] !== 1'b0) begin n_err++; $display("FAIL reset_full dut%0d got %b want 0", w, full_v[w]); end
            n_vec++; if (lvl_of(w) != 0) begin n_err++; $display("FAIL reset_level dut%0d got %0d want 0", w, lvl_of(w)); end
            n_vec++; if (ovr_v[w] !== 1'b0) begin n_err++; $display("FAIL reset_overrun dut%0d got %b want 0", w, ovr_v[w]); end
            n_vec++; if (fc_of(w) !== 16'd0) begin n_err++; $display("FAIL reset_frame_cnt dut%0d got %0d want 0", w, fc_of(w)); end
            n_vec++; if (rd_of(w) !== 11'd0) begin n_err++; $display("FAIL reset_rd_data dut%0d got %h want 0", w, rd_of(w)); end
        end
    endtask

    task automatic test_basic();
        int          n = 0;
        bit          early = 0;
        int          flen = CPB * (1 + DB[0] + SB[0]);
        logic [10:0] e;
        en = 3'b001;
        fork
            send_frame(0, 9'h055, 1'b0, 2'b11);
            begin
                while (fc_a == 16'd0 && n < 200) begin
                    if (!empty_v[0]) early = 1;
                    @(negedge clk);
                    n++;
                end
            end
        join
        push_lat = n;
        model_frame(0, 9'h055, 1'b0, 2'b11);
        n_vec++; if (fc_a !== 16'd1) begin n_err++; $display("FAIL basic_frame_cnt got %0d want 1", fc_a); end
        n_vec++; if (push_lat <= flen - CPB || push_lat > flen + 4) begin n_err++; $display("FAIL basic_push_latency got %0d want %0d..%0d", push_lat, flen - CPB + 1, flen + 4); end
        n_vec++; if (early) begin n_err++; $display("FAIL basic_empty_early got 1 want 0"); end
        n_vec++; if (empty_v[0] !== 1'b0) begin n_err++; $display("FAIL basic_empty got %b want 0", empty_v[0]); end
        n_vec++; if (rd_of(0) !== 11'h055) begin n_err++; $display("FAIL basic_rd_data got %h want 055", rd_of(0)); end
        n_vec++; if (lvl_of(0) != 1) begin n_err++; $display("FAIL basic_level got %0d want 1", lvl_of(0)); end
        repeat (4) @(negedge clk);
        q_pop(0, e);
        rd_en[0] = 1'b1; @(negedge clk); rd_en[0] = 1'b0;
        n_vec++; if (empty_v[0] !== 1'b1 || rd_of(0) !== 11'd0) begin n_err++; $display("FAIL basic_pop got empty=%b rd=%h want empty=1 rd=0", empty_v[0], rd_of(0)); end
    endtask

    task automatic test_parity();
        logic [10:0] e;
        logic [8:0]  d;
        logic        p;
        en = 3'b010;
        send_frame(1, 9'h0A7, 1'b0, 2'b11); model_frame(1, 9'h0A7, 1'b0, 2'b11); repeat (6) @(negedge clk);
        send_frame(1, 9'h0A7, 1'b1, 2'b11); model_frame(1, 9'h0A7, 1'b1, 2'b11); repeat (6) @(negedge clk);
        n_vec++; if (rd_of(1) !== 11'h2A7) begin n_err++; $display("FAIL parity_even_bad got %h want 2a7", rd_of(1)); end
        n_vec++; if (lvl_of(1) != 2) begin n_err++; $display("FAIL parity_level got %0d want 2", lvl_of(1)); end
        en = 3'b100;
        for (int k = 0; k < 3; k++) begin
            d = 9'($urandom_range(0, 127));
            p = 1'($urandom_range(0, 1));
            send_frame(2, d, p, 2'b11); model_frame(2, d, p, 2'b11); repeat (6) @(negedge clk);
        end
        for (int w = 1; w < 3; w++) begin
            while (q_size(w) > 0) begin
                q_pop(w, e);
                n_vec++; if (rd_of(w) !== e) begin n_err++; $display("FAIL parity_word dut%0d got %h want %h", w, rd_of(w), e); end
                rd_en[w] = 1'b1; @(negedge clk); rd_en[w] = 1'b0;
            end
        end
    endtask

    task automatic test_frame_err();
        logic [10:0] e;
        en = 3'b001;
        send_frame(0, 9'h03C, 1'b0, 2'b10); model_frame(0, 9'h03C, 1'b0, 2'b10); repeat (6) @(negedge clk);
        send_frame(0, 9'h001, 1'b0, 2'b11); model_frame(0, 9'h001, 1'b0, 2'b11); repeat (6) @(negedge clk);
        n_vec++; if (rd_of(0) !== 11'h13C) begin n_err++; $display("FAIL frame_err_word got %h want 13c", rd_of(0)); end
        while (q_size(0) > 0) begin
            q_pop(0, e);
            n_vec++; if (rd_of(0) !== e) begin n_err++; $display("FAIL frame_err_seq got %h want %h", rd_of(0), e); end
            rd_en[0] = 1'b1; @(negedge clk); rd_en[0] = 1'b0;
        end
    endtask

    task automatic test_glitch();
        logic [10:0] e;
        en = 3'b001;
        rxd = 1'b0;
        repeat ($urandom_range(1, CPB / 2)) @(negedge clk);
        rxd = 1'b1;
        repeat (60) @(negedge clk);
        n_vec++; if (fc_a !== 16'(fc_exp[0])) begin n_err++; $display("FAIL glitch_frame_cnt got %0d want %0d", fc_a, fc_exp[0]); end
        n_vec++; if (empty_v[0] !== 1'b1) begin n_err++; $display("FAIL glitch_empty got %b want 1", empty_v[0]); end
        send_frame(0, 9'h081, 1'b0, 2'b11); model_frame(0, 9'h081, 1'b0, 2'b11); repeat (6) @(negedge clk);
        q_pop(0, e);
        n_vec++; if (rd_of(0) !== e) begin n_err++; $display("FAIL glitch_rearm got %h want %h", rd_of(0), e); end
        rd_en[0] = 1'b1; @(negedge clk); rd_en[0] = 1'b0;
    endtask

    task automatic test_overrun();
        logic [10:0] e;
        logic [8:0]  d;
        en = 3'b001;
        for (int k = 0; k < 4; k++) begin
            d = 9'($urandom_range(0, 255));
            send_frame(0, d, 1'b0, 2'b11); model_frame(0, d, 1'b0, 2'b11); repeat (6) @(negedge clk);
        end
        // Fifth frame is dropped while clr_err is asserted in the same cycle.
        d = 9'($urandom_range(0, 255));
        fork
            send_frame(0, d, 1'b0, 2'b11);
            begin
                repeat (push_lat - 1) @(negedge clk);
                clr_err[0] = 1'b1; @(negedge clk); clr_err[0] = 1'b0;
            end
        join
        model_frame(0, d, 1'b0, 2'b11);
        repeat (6) @(negedge clk);
        n_vec++; if (full_v[0] !== 1'b1) begin n_err++; $display("FAIL ovr_full got %b want 1", full_v[0]); end
        n_vec++; if (lvl_of(0) != 4) begin n_err++; $display("FAIL ovr_level got %0d want 4", lvl_of(0)); end
        n_vec++; if (ovr_v[0] !== ovr_exp[0]) begin n_err++; $display("FAIL ovr_set got %b want %b", ovr_v[0], ovr_exp[0]); end
        n_vec++; if (rd_of(0) !== q_head(0)) begin n_err++; $display("FAIL ovr_head got %h want %h", rd_of(0), q_head(0)); end
        n_vec++; if (fc_a !== 16'(fc_exp[0])) begin n_err++; $display("FAIL ovr_frame_cnt got %0d want %0d", fc_a, fc_exp[0]); end
        clr_err[0] = 1'b1; @(negedge clk); clr_err[0] = 1'b0; ovr_exp[0] = 1'b0;
        n_vec++; if (ovr_v[0] !== 1'b0) begin n_err++; $display("FAIL ovr_clear got %b want 0", ovr_v[0]); end
        while (q_size(0) > 0) begin
            q_pop(0, e);
            n_vec++; if (rd_of(0) !== e) begin n_err++; $display("FAIL ovr_drain got %h want %h", rd_of(0), e); end
            rd_en[0] = 1'b1; @(negedge clk); rd_en[0] = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            d = 9'($urandom_range(0, 255));
            send_frame(0, d, 1'b0, 2'b11); model_frame(0, d, 1'b0, 2'b11); repeat (6) @(negedge clk);
        end
        // Fifth frame lands together with a pop, so it must be accepted.
        d = 9'($urandom_range(0, 255));
        fork
            send_frame(0, d, 1'b0, 2'b11);
            begin
                repeat (push_lat - 1) @(negedge clk);
                rd_en[0] = 1'b1; @(negedge clk); rd_en[0] = 1'b0;
            end
        join
        q_pop(0, e);
        model_frame(0, d, 1'b0, 2'b11);
        repeat (6) @(negedge clk);
        n_vec++; if (lvl_of(0) != 4) begin n_err++; $display("FAIL ovr_pop_level got %0d want 4", lvl_of(0)); end
        n_vec++; if (ovr_v[0] !== 1'b0) begin n_err++; $display("FAIL ovr_pop_overrun got %b want 0", ovr_v[0]); end
        while (q_size(0) > 0) begin
            q_pop(0, e);
            n_vec++; if (rd_of(0) !== e) begin n_err++; $display("FAIL ovr_pop_drain got %h want %h", rd_of(0), e); end
            rd_en[0] = 1'b1; @(negedge clk); rd_en[0] = 1'b0;
        end
    endtask

    task automatic test_enable();
        logic [10:0] e;
        logic [8:0]  d;
        en = 3'b001;
        d = 9'($urandom_range(0, 255));
        fork
            send_frame(0, d, 1'b0, 2'b11);
            begin
                repeat (12) @(negedge clk);
                en[0] = 1'b0;
            end
        join
        model_frame(0, d, 1'b0, 2'b11);
        repeat (6) @(negedge clk);
        n_vec++; if (fc_a !== 16'(fc_exp[0])) begin n_err++; $display("FAIL en_complete_cnt got %0d want %0d", fc_a, fc_exp[0]); end
        send_frame(0, 9'h0F0, 1'b0, 2'b11);
        repeat (6) @(negedge clk);
        n_vec++; if (fc_a !== 16'(fc_exp[0]) || lvl_of(0) != 1) begin n_err++; $display("FAIL en_blocked got cnt=%0d lvl=%0d want cnt=%0d lvl=1", fc_a, lvl_of(0), fc_exp[0]); end
        q_pop(0, e);
        n_vec++; if (rd_of(0) !== e) begin n_err++; $display("FAIL en_word got %h want %h", rd_of(0), e); end
        rd_en[0] = 1'b1; @(negedge clk); rd_en[0] = 1'b0;
    endtask

    task automatic test_random();
        logic [10:0] e;
        logic [8:0]  d;
        logic        p;
        logic [1:0]  s;
        int          w;
        for (int k = 0; k < 30; k++) begin
            w  = $urandom_range(0, 2);
            en = 3'(1 << w);
            d  = 9'($urandom_range(0, 511));
            p  = 1'($urandom_range(0, 1));
            s  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
            send_frame(w, d, p, s); model_frame(w, d, p, s); repeat (6) @(negedge clk);
            if (q_size(w) == DEP[w] || $urandom_range(0, 3) == 0) begin
                while (q_size(w) > 0) begin
                    q_pop(w, e);
                    n_vec++; if (rd_of(w) !== e) begin n_err++; $display("FAIL rand_word dut%0d got %h want %h", w, rd_of(w), e); end
                    rd_en[w] = 1'b1; @(negedge clk); rd_en[w] = 1'b0;
                end
            end
        end
        for (int v = 0; v < 3; v++) begin
            while (q_size(v) > 0) begin
                q_pop(v, e);
                n_vec++; if (rd_of(v) !== e) begin n_err++; $display("FAIL rand_drain dut%0d got %h want %h", v, rd_of(v), e); end
                rd_en[v] = 1'b1; @(negedge clk); rd_en[v] = 1'b0;
            end
            n_vec++; if (fc_of(v) !== 16'(fc_exp[v])) begin n_err++; $display("FAIL rand_frame_cnt dut%0d got %0d want %0d", v, fc_of(v), fc_exp[v]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] e;
        logic [8:0]  d;
        en = 3'b001;
        send_frame(0, 9'h0AA, 1'b0, 2'b11); model_frame(0, 9'h0AA, 1'b0, 2'b11); repeat (6) @(negedge clk);
        d = 9'h05A;
        rxd = 1'b0; repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd = d[i]; repeat (CPB) @(negedge clk);
        end
        rxd = 1'b1; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q0.delete(); exp_q1.delete(); exp_q2.delete();
        ovr_exp = '0; fc_exp = '{0, 0, 0};
        for (int w = 0; w < 3; w++) begin
            n_vec++;
            if (empty_v[w] !== 1'b1 || full_v[w] !== 1'b0 || lvl_of(w) != 0 || ovr_v[w] !== 1'b0 ||
                fc_of(w) !== 16'd0 || rd_of(w) !== 11'd0) begin
                n_err++;
                $display("FAIL midreset_outputs dut%0d got empty=%b full=%b lvl=%0d ovr=%b cnt=%0d rd=%h want 1 0 0 0 0 0",
                         w, empty_v[w], full_v[w], lvl_of(w), ovr_v[w], fc_of(w), rd_of(w));
            end
        end
        repeat (20) @(negedge clk);
        n_vec++; if (empty_v[0] !== 1'b1 || fc_a !== 16'd0) begin n_err++; $display("FAIL midreset_no_push got empty=%b cnt=%0d want 1 0", empty_v[0], fc_a); end
        send_frame(0, 9'h0C3, 1'b0, 2'b11); model_frame(0, 9'h0C3, 1'b0, 2'b11); repeat (6) @(negedge clk);
        n_vec++; if (rd_of(0) !== 11'h0C3 || fc_a !== 16'd1) begin n_err++; $display("FAIL midreset_c3 got rd=%h cnt=%0d want 0c3 1", rd_of(0), fc_a); end
        q_pop(0, e);
        rd_en[0] = 1'b1; @(negedge clk); rd_en[0] = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_enable();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
